// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, decoded code type and monitor state encoding.
package seg7_pkg;

  // Active-low segment patterns, bit6=a ... bit0=g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int unsigned CODE_W = 4;

  // 0..9 are BCD digits; two reserved values mark blank and illegal patterns
  typedef logic [CODE_W-1:0] code_t;
  localparam code_t CODE_BLANK   = 4'hA;
  localparam code_t CODE_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_DIGIT,
    ST_BLANK,
    ST_ILLEGAL
  } state_t;

  // Next BCD digit with 9 -> 0 wrap
  function automatic code_t bcd_next(input code_t d);
    return (d == 4'd9) ? 4'd0 : CODE_W'(d + 4'd1);
  endfunction

  // Previous BCD digit with 0 -> 9 wrap
  function automatic code_t bcd_prev(input code_t d);
    return (d == 4'd0) ? 4'd9 : CODE_W'(d - 4'd1);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low 7-segment pattern to code decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code_c
);

  // Exact-match lookup; anything unrecognised is flagged illegal
  always_comb begin
    code_c = CODE_ILLEGAL;
    case (seg)
      SEG_0:     code_c = 4'd0;
      SEG_1:     code_c = 4'd1;
      SEG_2:     code_c = 4'd2;
      SEG_3:     code_c = 4'd3;
      SEG_4:     code_c = 4'd4;
      SEG_5:     code_c = 4'd5;
      SEG_6:     code_c = 4'd6;
      SEG_7:     code_c = 4'd7;
      SEG_8:     code_c = 4'd8;
      SEG_9:     code_c = 4'd9;
      SEG_BLANK: code_c = CODE_BLANK;
      default:   code_c = CODE_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/seg7_digit_monitor.sv
// Debounces a sampled 7-segment display, decodes it and classifies digit-to-digit steps.
module seg7_digit_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_N = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             illegal,
  output logic             step_up,
  output logic             step_down,
  output logic             jump,
  output logic [CNT_W-1:0] up_count,
  output logic [CNT_W-1:0] down_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned STAB_W   = 4;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  code_t             code_c;
  code_t             cand;
  logic [STAB_W-1:0] stab;
  logic [STAB_W-1:0] stab_nxt_c;
  code_t             acc_code_c;
  logic              accept_c;
  state_t            state;

  seg7_decode u_decode (
    .seg    (seg_in),
    .code_c (code_c)
  );

  // Next stability count and acceptance decision for the current sample
  always_comb begin
    stab_nxt_c = '0;
    acc_code_c = CODE_ILLEGAL;
    if (code_c == cand) begin
      stab_nxt_c = (stab == STAB_MAX) ? STAB_MAX : STAB_W'(stab + 4'd1);
    end
    case (state)
      ST_DIGIT:   acc_code_c = digit;
      ST_BLANK:   acc_code_c = CODE_BLANK;
      default:    acc_code_c = CODE_ILLEGAL;
    endcase
    accept_c = sample_en && (stab_nxt_c == STAB_MAX) &&
               ((state == ST_EMPTY) || (code_c != acc_code_c));
  end

  // Stability filter: candidate code and run length, advanced only on sample strobes
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      cand <= CODE_ILLEGAL;
      stab <= '0;
    end else if (sample_en) begin
      cand <= code_c;
      stab <= stab_nxt_c;
    end
  end

  // Accepted-class state machine with registered flags, pulses and saturating counters
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      digit       <= '0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      illegal     <= 1'b0;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      jump        <= 1'b0;
      up_count    <= '0;
      down_count  <= '0;
      err_count   <= '0;
    end else begin
      step_up   <= 1'b0;
      step_down <= 1'b0;
      jump      <= 1'b0;
      if (accept_c) begin
        if (code_c == CODE_BLANK) begin
          state       <= ST_BLANK;
          blank       <= 1'b1;
          illegal     <= 1'b0;
          digit_valid <= 1'b0;
        end else if (code_c == CODE_ILLEGAL) begin
          state       <= ST_ILLEGAL;
          illegal     <= 1'b1;
          blank       <= 1'b0;
          digit_valid <= 1'b0;
          if (err_count != CNT_MAX) err_count <= CNT_W'(err_count + 1'b1);
        end else begin
          state       <= ST_DIGIT;
          digit       <= code_c;
          digit_valid <= 1'b1;
          blank       <= 1'b0;
          illegal     <= 1'b0;
          // Direction is only meaningful between two consecutive accepted digits
          if (state == ST_DIGIT) begin
            if (code_c == bcd_next(digit)) begin
              step_up <= 1'b1;
              if (up_count != CNT_MAX) up_count <= CNT_W'(up_count + 1'b1);
            end else if (code_c == bcd_prev(digit)) begin
              step_down <= 1'b1;
              if (down_count != CNT_MAX) down_count <= CNT_W'(down_count + 1'b1);
            end else begin
              jump <= 1'b1;
              if (err_count != CNT_MAX) err_count <= CNT_W'(err_count + 1'b1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_digit_monitor.sv
// Scoreboard bench: run-length reference model predicts accepted events, monitor checks DUT.
module tb_seg7_digit_monitor;

  localparam int STABLE_N = 4;
  localparam int CW       = 4;
  localparam int CMAX     = (1 << CW) - 1;

  typedef struct packed {
    logic [3:0]    digit;
    logic          dv;
    logic          blank;
    logic          illegal;
    logic          up;
    logic          down;
    logic          jump;
    logic [CW-1:0] upc;
    logic [CW-1:0] dnc;
    logic [CW-1:0] erc;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en = 1'b0;
  logic [6:0]    seg_in = 7'h7f;
  logic [3:0]    digit;
  logic          digit_valid, blank, illegal, step_up, step_down, jump;
  logic [CW-1:0] up_count, down_count, err_count;

  int total = 0;
  int bad   = 0;

  seg7_digit_monitor #(.STABLE_N(STABLE_N), .CNT_W(CW)) dut (
    .CLOCK_50    (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .seg_in      (seg_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .illegal     (illegal),
    .step_up     (step_up),
    .step_down   (step_down),
    .jump        (jump),
    .up_count    (up_count),
    .down_count  (down_count),
    .err_count   (err_count)
  );

  always #10 clk = ~clk;

  // Reference patterns, written out independently of the design package
  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
  end

  // Model: class 0=none yet, 1=digit, 2=blank, 3=illegal; codes 0..9, 10=blank, 15=illegal
  obs_t q[$];
  int   run_code, run_len, m_class, m_digit, m_code, m_up, m_dn, m_er;

  function automatic int ref_decode(input logic [6:0] pat);
    for (int i = 0; i < 10; i++) if (pat == seg_tab[i]) return i;
    if (pat == 7'b1111111) return 10;
    return 15;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    run_code = 15; run_len = 1;
    m_class = 0; m_digit = 0; m_code = 15;
    m_up = 0; m_dn = 0; m_er = 0;
    q.delete();
  endtask

  task automatic model_sample(input logic [6:0] pat);
    int   c;
    obs_t e;
    c = ref_decode(pat);
    if (c == run_code) run_len++;
    else begin run_code = c; run_len = 1; end
    if (run_len != STABLE_N) return;
    if (m_class != 0 && c == m_code) return;
    e = '0;
    if (c == 10) m_class = 2;
    else if (c == 15) begin m_class = 3; m_er = sat(m_er); end
    else begin
      if (m_class == 1) begin
        if (c == (m_digit + 1) % 10)      begin e.up = 1'b1;   m_up = sat(m_up); end
        else if (c == (m_digit + 9) % 10) begin e.down = 1'b1; m_dn = sat(m_dn); end
        else                              begin e.jump = 1'b1; m_er = sat(m_er); end
      end
      m_class = 1; m_digit = c;
    end
    m_code    = c;
    e.digit   = 4'(m_digit);
    e.dv      = (m_class == 1);
    e.blank   = (m_class == 2);
    e.illegal = (m_class == 3);
    e.upc     = CW'(m_up);
    e.dnc     = CW'(m_dn);
    e.erc     = CW'(m_er);
    q.push_back(e);
  endtask

  // Monitor: any pulse or change of the display flags/digit is one DUT event
  logic rst_edge = 1'b1;
  obs_t prev = '0;
  always @(posedge clk) rst_edge <= !rst_n;

  always @(negedge clk) begin
    obs_t cur, e;
    cur = {digit, digit_valid, blank, illegal, step_up, step_down, jump,
           up_count, down_count, err_count};
    if (rst_edge) begin
      total++;
      if (cur != '0) begin
        bad++;
        $display("FAIL reset_state got=%h want=0", cur);
      end
      prev = '0;
    end else begin
      if (cur.up || cur.down || cur.jump ||
          cur[$bits(obs_t)-1 -: 7] != prev[$bits(obs_t)-1 -: 7]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got=%h want=no_event", cur);
        end else begin
          e = q.pop_front();
          if (cur != e) begin
            bad++;
            $display("FAIL event t=%0t got=%h want=%h", $time, cur, e);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic drive(input logic [6:0] pat, input logic en);
    @(posedge clk); #1;
    sample_en = en;
    seg_in    = pat;
    if (en) model_sample(pat);
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    for (int i = 0; i < n; i++) drive(pat, 1'b1);
  endtask

  task automatic do_reset();
    drive(7'h7f, 1'b0);
    drive(7'h7f, 1'b0);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    sample_en = 1'($urandom_range(0, 1));
    seg_in    = seg_tab[$urandom_range(0, 9)];
    model_reset();
    @(posedge clk); #1;
    rst_n     = 1'b1;
    sample_en = 1'b0;
  endtask

  initial begin
    int d;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First digit: three samples are not enough, the fourth accepts
    hold(seg_tab[0], 3);
    drive(7'h7f, 1'b0);
    hold(seg_tab[0], 1);
    // 0 -> 9 step down, 9 -> 0 step up, 0 -> 9 step down
    hold(seg_tab[9], 4);
    hold(seg_tab[0], 4);
    hold(seg_tab[9], 4);
    // 3 then 7 is a jump
    hold(seg_tab[3], 4);
    hold(seg_tab[7], 4);
    // Interrupted run of 3, glitch of 4 never accepted
    hold(seg_tab[3], 2);
    hold(seg_tab[4], 1);
    hold(seg_tab[3], 4);
    // 5, blank, 8 (first digit again), illegal
    hold(seg_tab[5], 4);
    hold(7'b1111111, 4);
    hold(seg_tab[8], 4);
    hold(7'b1010101, 4);
    // Saturate the up counter
    for (int i = 0; i < 20; i++) hold(seg_tab[i % 10], 4);
    // Saturate down and error counters
    for (int i = 20; i > 0; i--) hold(seg_tab[i % 10], 4);
    for (int i = 0; i < 20; i++) hold(seg_tab[(i * 5) % 10], 4);
    // Reset mid-stability discards the partial run
    hold(seg_tab[2], 2);
    do_reset();
    hold(seg_tab[2], 2);
    drive(7'h7f, 1'b0);
    hold(seg_tab[2], 2);

    // Randomized runs with idle cycles, glitches, blanks and illegal patterns
    d = 0;
    for (int k = 0; k < 400; k++) begin
      int   kind, len;
      logic [6:0] pat;
      kind = $urandom_range(0, 99);
      if (kind < 40)      begin d = (d + 1) % 10; pat = seg_tab[d]; end
      else if (kind < 60) begin d = (d + 9) % 10; pat = seg_tab[d]; end
      else if (kind < 75) begin d = $urandom_range(0, 9); pat = seg_tab[d]; end
      else if (kind < 85) pat = 7'b1111111;
      else                pat = 7'($urandom);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) drive(7'($urandom), 1'b0);
        drive(pat, 1'b1);
      end
      if ($urandom_range(0, 99) < 2) do_reset();
    end

    repeat (4) drive(7'h7f, 1'b0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
